// File: rtl/instr_fetch_if.sv
// Bundle of the instruction-memory bus, the decode handshake and the redirect
// path for instr_fetch. master = fetch unit, slave = memory/decode/branch side.
//
// Handshakes:
//   imem:   imem_req is held with a stable imem_addr until a single-cycle
//           imem_ack pulse returns imem_rdata.
//   decode: an instruction transfers on a cycle where instr_valid && instr_ready;
//           instr, opcode and pc_out are stable while instr_valid waits for ready.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_out;

  logic        redirect;
  logic [31:0] redirect_pc;

  logic [15:0] fetch_count;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, opcode, pc_out,
    input  instr_ready,
    input  redirect, redirect_pc,
    output fetch_count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, opcode, pc_out,
    output instr_ready,
    output redirect, redirect_pc,
    input  fetch_count
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one memory read at a time, holds the returned
// word in the IR until decode accepts it, and restarts fetch on redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  instr_fetch_if.master bus,
  output logic [1:0]  dbg_state,
  output logic [31:0] dbg_pc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] VALID = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] addr_q;
  logic [31:0] ir_q;
  logic [31:0] pc_out_q;
  logic [15:0] count_q;
  logic        load_addr;
  logic        capture;
  logic        take;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    load_addr  = 1'b0;
    capture    = 1'b0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        state_next = FETCH;
        load_addr  = 1'b1;
        if (bus.redirect) pc_next = bus.redirect_pc;
      end
      FETCH: begin
        if (bus.redirect) begin
          // A request already in flight must still be acknowledged, so a
          // redirect without ack parks in DRAIN with the old address held.
          pc_next = bus.redirect_pc;
          if (bus.imem_ack) begin
            state_next = FETCH;
            load_addr  = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end else if (bus.imem_ack) begin
          capture    = 1'b1;
          pc_next    = addr_q + PC_STEP;
          state_next = VALID;
        end
      end
      VALID: begin
        if (bus.redirect) begin
          pc_next    = bus.redirect_pc;
          state_next = FETCH;
          load_addr  = 1'b1;
        end else if (bus.instr_ready) begin
          take       = 1'b1;
          state_next = FETCH;
          load_addr  = 1'b1;
        end
      end
      DRAIN: begin
        if (bus.redirect) pc_next = bus.redirect_pc;
        if (bus.imem_ack) begin
          state_next = FETCH;
          load_addr  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      addr_q   <= 32'h0;
      ir_q     <= 32'h0;
      pc_out_q <= 32'h0;
      count_q  <= 16'h0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (load_addr) addr_q <= pc_next;
      if (capture) begin
        ir_q     <= bus.imem_rdata;
        pc_out_q <= addr_q;
      end
      if (take && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
    end
  end

  assign bus.imem_req    = (state == FETCH) || (state == DRAIN);
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = (state == VALID);
  assign bus.instr       = ir_q;
  assign bus.opcode      = ir_q[31:26];
  assign bus.pc_out      = pc_out_q;
  assign bus.fetch_count = count_q;

  assign dbg_state = state;
  assign dbg_pc    = pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomised scenarios for instr_fetch; accepted instructions are
// predicted into a scoreboard queue and compared at each decode handshake.
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_FETCH = 2'd1;
  localparam logic [1:0]  S_VALID = 2'd2;
  localparam logic [1:0]  S_DRAIN = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  dbg_state;
  logic [31:0] dbg_pc;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_i;
  logic [31:0] exp_p;
  logic [31:0] last_instr;
  logic [15:0] exp_count;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state),
    .dbg_pc   (dbg_pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks (called at a falling edge with the DUT in FETCH)
  task automatic drive_ack(input int delay, input logic [31:0] data);
    for (int i = 0; i < delay; i++) begin
      bus.imem_ack = 1'b0;
      @(negedge clk);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] data, input logic [31:0] addr);
    exp_q.push_back(data);
    exp_pc_q.push_back(addr);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    exp_count = 16'h0; last_instr = 32'h0;
    @(negedge clk); @(negedge clk);
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
    checks++; if (dbg_pc !== RESET_PC) begin failures++; $display("FAIL reset_pc: got %h want %h", dbg_pc, RESET_PC); end
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_ctrl: req=%b valid=%b want 0 0", bus.imem_req, bus.instr_valid); end
    checks++; if (bus.imem_addr !== 32'h0 || bus.instr !== 32'h0 || bus.pc_out !== 32'h0) begin failures++; $display("FAIL reset_regs: addr=%h instr=%h pc_out=%h want 0", bus.imem_addr, bus.instr, bus.pc_out); end
    checks++; if (bus.fetch_count !== 16'h0) begin failures++; $display("FAIL reset_count: got %0d want 0", bus.fetch_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait;
    @(negedge clk);
    checks++; if (dbg_state !== S_FETCH || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL first_fetch: state=%0d req=%b addr=%h want 1 1 0", dbg_state, bus.imem_req, bus.imem_addr); end
    push_exp(32'h8C22_0004, 32'h0);
    bus.instr_ready = 1'b1;
    drive_ack(0, 32'h8C22_0004);
    checks++; if (bus.instr_valid !== 1'b1 || bus.opcode !== 6'b100011) begin failures++; $display("FAIL zw_valid: valid=%b opcode=%b want 1 100011", bus.instr_valid, bus.opcode); end
    exp_i = exp_q.pop_front(); exp_p = exp_pc_q.pop_front();
    checks++; if (bus.instr !== exp_i || bus.pc_out !== exp_p) begin failures++; $display("FAIL zw_instr: instr=%h pc=%h want %h %h", bus.instr, bus.pc_out, exp_i, exp_p); end
    @(negedge clk);
    bus.instr_ready = 1'b0;
    exp_count++; last_instr = exp_i;
    checks++; if (bus.imem_addr !== 32'h4 || bus.fetch_count !== exp_count || dbg_state !== S_FETCH) begin failures++; $display("FAIL zw_next: addr=%h count=%0d state=%0d want 4 %0d 1", bus.imem_addr, bus.fetch_count, dbg_state, exp_count); end
  endtask

  task automatic test_wait_states;
    logic [31:0] d;
    d = $urandom;
    push_exp(d, 32'h4);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL wait_hold[%0d]: req=%b addr=%h valid=%b want 1 4 0", i, bus.imem_req, bus.imem_addr, bus.instr_valid); end
      bus.imem_ack = (i == 3); bus.imem_rdata = d;
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL wait_valid: got %b want 1", bus.instr_valid); end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== exp_q[0] || bus.imem_req !== 1'b0 || bus.fetch_count !== exp_count) begin failures++; $display("FAIL stall_hold[%0d]: valid=%b instr=%h req=%b count=%0d want 1 %h 0 %0d", i, bus.instr_valid, bus.instr, bus.imem_req, bus.fetch_count, exp_q[0], exp_count); end
      // a stray ack while holding must not disturb the IR
      bus.imem_ack = (i == 2); bus.imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b1;
    exp_i = exp_q.pop_front(); exp_p = exp_pc_q.pop_front();
    checks++; if (bus.instr !== exp_i || bus.pc_out !== exp_p) begin failures++; $display("FAIL stall_instr: instr=%h pc=%h want %h %h", bus.instr, bus.pc_out, exp_i, exp_p); end
    @(negedge clk);
    bus.instr_ready = 1'b0;
    exp_count++; last_instr = exp_i;
    checks++; if (bus.fetch_count !== exp_count || bus.imem_addr !== 32'h8) begin failures++; $display("FAIL stall_next: count=%0d addr=%h want %0d 8", bus.fetch_count, bus.imem_addr, exp_count); end
  endtask

  task automatic test_redirect_drain;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    @(negedge clk);
    bus.redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (dbg_state !== S_DRAIN || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL drain_hold[%0d]: state=%0d req=%b addr=%h valid=%b want 3 1 8 0", i, dbg_state, bus.imem_req, bus.imem_addr, bus.instr_valid); end
      if (i == 1) begin bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; end
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    checks++; if (dbg_state !== S_FETCH || bus.imem_addr !== 32'h100 || bus.instr_valid !== 1'b0 || bus.instr !== last_instr) begin failures++; $display("FAIL drain_exit: state=%0d addr=%h valid=%b instr=%h want 1 100 0 %h", dbg_state, bus.imem_addr, bus.instr_valid, bus.instr, last_instr); end
  endtask

  task automatic test_last_redirect_wins;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    @(negedge clk);
    bus.redirect_pc = 32'h300;
    @(negedge clk);
    bus.redirect_pc = 32'h400; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus.redirect = 1'b0; bus.imem_ack = 1'b0;
    checks++; if (dbg_state !== S_FETCH || bus.imem_addr !== 32'h400 || bus.instr !== last_instr) begin failures++; $display("FAIL last_wins: state=%0d addr=%h instr=%h want 1 400 %h", dbg_state, bus.imem_addr, bus.instr, last_instr); end
  endtask

  task automatic test_redirect_with_ack;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h500; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.redirect = 1'b0; bus.imem_ack = 1'b0;
    checks++; if (dbg_state !== S_FETCH || bus.imem_addr !== 32'h500 || bus.instr_valid !== 1'b0 || bus.instr !== last_instr) begin failures++; $display("FAIL redir_ack: state=%0d addr=%h valid=%b instr=%h want 1 500 0 %h", dbg_state, bus.imem_addr, bus.instr_valid, bus.instr, last_instr); end
  endtask

  task automatic test_redirect_in_valid;
    logic [31:0] d;
    d = $urandom;
    push_exp(d, 32'h500);
    drive_ack(0, d);
    exp_i = exp_q.pop_front(); exp_p = exp_pc_q.pop_front();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== exp_i || bus.pc_out !== exp_p) begin failures++; $display("FAIL rv_instr: valid=%b instr=%h pc=%h want 1 %h %h", bus.instr_valid, bus.instr, bus.pc_out, exp_i, exp_p); end
    bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h600;
    @(negedge clk);
    bus.instr_ready = 1'b0; bus.redirect = 1'b0;
    last_instr = d;
    checks++; if (bus.fetch_count !== exp_count || bus.imem_addr !== 32'h600 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rv_next: count=%0d addr=%h valid=%b want %0d 600 0", bus.fetch_count, bus.imem_addr, bus.instr_valid, exp_count); end
  endtask

  task automatic test_wrap;
    logic [31:0] d;
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.redirect = 1'b0; bus.imem_ack = 1'b0;
    d = $urandom;
    push_exp(d, 32'hFFFF_FFFC);
    drive_ack(0, d);
    bus.instr_ready = 1'b1;
    exp_i = exp_q.pop_front(); exp_p = exp_pc_q.pop_front();
    checks++; if (bus.instr !== exp_i || bus.pc_out !== exp_p) begin failures++; $display("FAIL wrap_instr: instr=%h pc=%h want %h %h", bus.instr, bus.pc_out, exp_i, exp_p); end
    @(negedge clk);
    bus.instr_ready = 1'b0;
    exp_count++; last_instr = exp_i;
    checks++; if (bus.imem_addr !== 32'h0 || bus.fetch_count !== exp_count) begin failures++; $display("FAIL wrap_next: addr=%h count=%0d want 0 %0d", bus.imem_addr, bus.fetch_count, exp_count); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_addr;
    logic [31:0] d;
    int delay;
    int stall;
    exp_addr = 32'h0;
    for (int n = 0; n < 12; n++) begin
      delay = $urandom_range(0, 2);
      stall = $urandom_range(0, 2);
      d = $urandom;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr) begin failures++; $display("FAIL b2b_addr[%0d]: req=%b addr=%h want 1 %h", n, bus.imem_req, bus.imem_addr, exp_addr); end
      push_exp(d, exp_addr);
      bus.instr_ready = (stall == 0);
      drive_ack(delay, d);
      for (int s = 0; s < stall; s++) @(negedge clk);
      bus.instr_ready = 1'b1;
      if (exp_q.size() == 0) begin
        checks++; failures++; $display("FAIL b2b_queue[%0d]: got empty want 1 entry", n);
      end else begin
        exp_i = exp_q.pop_front(); exp_p = exp_pc_q.pop_front();
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== exp_i || bus.pc_out !== exp_p) begin failures++; $display("FAIL b2b_instr[%0d]: valid=%b instr=%h pc=%h want 1 %h %h", n, bus.instr_valid, bus.instr, bus.pc_out, exp_i, exp_p); end
      end
      @(negedge clk);
      bus.instr_ready = 1'b0;
      exp_count++; last_instr = d;
      exp_addr = exp_addr + 32'd4;
    end
    checks++; if (bus.fetch_count !== exp_count) begin failures++; $display("FAIL b2b_count: got %0d want %0d", bus.fetch_count, exp_count); end
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    bus.instr_ready = 1'b0;
    drive_ack(0, 32'hCAFE_F00D);
    #2 rst_n = 1'b0;
    #1;
    exp_count = 16'h0; last_instr = 32'h0;
    checks++; if (bus.instr_valid !== 1'b0 || dbg_pc !== RESET_PC || dbg_state !== S_IDLE || bus.fetch_count !== 16'h0 || bus.instr !== 32'h0) begin failures++; $display("FAIL async_reset: valid=%b pc=%h state=%0d count=%0d instr=%h want 0 %h 0 0 0", bus.instr_valid, dbg_pc, dbg_state, bus.fetch_count, bus.instr, RESET_PC); end
    @(negedge clk);
    // an ack landing while still in IDLE must be ignored
    rst_n = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFACE_0FF0;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    checks++; if (dbg_state !== S_FETCH || bus.instr !== 32'h0 || bus.imem_addr !== RESET_PC) begin failures++; $display("FAIL idle_ack: state=%0d instr=%h addr=%h want 1 0 %h", dbg_state, bus.instr, bus.imem_addr, RESET_PC); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || dbg_state !== S_IDLE) begin failures++; $display("FAIL fetch_reset: req=%b state=%0d want 0 0", bus.imem_req, dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d = $urandom;
    push_exp(d, RESET_PC);
    drive_ack(1, d);
    bus.instr_ready = 1'b1;
    exp_i = exp_q.pop_front(); exp_p = exp_pc_q.pop_front();
    checks++; if (bus.instr !== exp_i || bus.pc_out !== exp_p) begin failures++; $display("FAIL post_reset: instr=%h pc=%h want %h %h", bus.instr, bus.pc_out, exp_i, exp_p); end
    @(negedge clk);
    bus.instr_ready = 1'b0;
    exp_count++;
    checks++; if (bus.fetch_count !== exp_count) begin failures++; $display("FAIL post_reset_count: got %0d want %0d", bus.fetch_count, exp_count); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_drain();
    test_last_redirect_wins();
    test_redirect_with_ack();
    test_redirect_in_valid();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL queue_drained: got %0d want 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
